// File: rtl/bram_stream_reader.sv
// bram_stream_reader: walks a BRAM word range on start and streams the words
// out as valid/ready beats. The read latency is absorbed by a 2-entry skid
// FIFO with a credit-based issue rule, so the stream sustains 1 word/cycle.
// rd_addr is the BRAM's registered read address: a word issued at edge N
// shows up on rd_data during the following cycle and is captured at N+1.
// Optional feature: define BRAM_RD_STRIDE_EN to add the stride port
// (address increment sampled on start); otherwise the increment is 1.
module bram_stream_reader #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 30
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
`ifdef BRAM_RD_STRIDE_EN
    input  logic [ADDR_WIDTH-1:0] stride,
`endif
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;          // next address to issue
    logic [ADDR_WIDTH-1:0]   inc_q, inc_d;
    logic [ADDR_WIDTH:0]     cnt_q, cnt_d;          // words still to issue
    logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
    logic                    infl_q, infl_d;        // word on rd_data this cycle
    logic                    infl_last_q, infl_last_d;
    logic [DATA_WIDTH-1:0]   fifo_data_q [2];
    logic [DATA_WIDTH-1:0]   fifo_data_d [2];
    logic [1:0]              fifo_last_q, fifo_last_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic [1:0]              fifo_cnt_q, fifo_cnt_d;

    logic                    pop;
    logic [2:0]              occ;
    logic                    issue;

    assign m_valid = (fifo_cnt_q != 2'd0);
    assign m_data  = fifo_data_q[rd_ptr_q];
    assign m_last  = fifo_last_q[rd_ptr_q] & m_valid;
    assign rd_addr = rd_addr_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);

    // Occupancy after this cycle's pop; one more word may issue if it stays <= 2
    assign pop   = m_valid & m_ready;
    assign occ   = 3'(infl_q) + 3'(fifo_cnt_q) - 3'(pop);
    assign issue = (state_q == S_RUN) && (occ <= 3'd1);

    // FSM next state plus address/count walk
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        inc_d       = inc_q;
        cnt_d       = cnt_q;
        rd_addr_d   = rd_addr_q;
        infl_d      = 1'b0;
        infl_last_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    ptr_d   = base_addr;
                    cnt_d   = length;
`ifdef BRAM_RD_STRIDE_EN
                    inc_d   = stride;
`else
                    inc_d   = ADDR_WIDTH'(1);
`endif
                    state_d = (length == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                if (issue) begin
                    rd_addr_d   = ptr_q;
                    ptr_d       = ptr_q + inc_q;    // wraps modulo depth
                    cnt_d       = cnt_q - 1'b1;
                    infl_d      = 1'b1;
                    infl_last_d = (cnt_q == (ADDR_WIDTH+1)'(1));
                    if (cnt_q == (ADDR_WIDTH+1)'(1))
                        state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && m_last)
                    state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Skid FIFO: capture the in-flight word, advance head on handshake
    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        fifo_cnt_d  = fifo_cnt_q + 2'(infl_q) - 2'(pop);
        if (infl_q) begin
            fifo_data_d[wr_ptr_q] = rd_data;
            fifo_last_d[wr_ptr_q] = infl_last_q;
            wr_ptr_d              = ~wr_ptr_q;
        end
        if (pop)
            rd_ptr_d = ~rd_ptr_q;
    end

    // State registers; reset discards in-flight and buffered words
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            inc_q       <= '0;
            cnt_q       <= '0;
            rd_addr_q   <= '0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            fifo_data_q <= '{default: '0};
            fifo_last_q <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            fifo_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            inc_q       <= inc_d;
            cnt_q       <= cnt_d;
            rd_addr_q   <= rd_addr_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            fifo_data_q <= fifo_data_d;
            fifo_last_q <= fifo_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: table of ranges with fixed expectations,
// hand sequences for busy-start and mid-run reset, then randomized ranges
// checked beat-by-beat against an address-list model of the range.
module tb_bram_stream_reader;
    localparam int AW    = 4;
    localparam int DW    = 30;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   length = '0;
`ifdef BRAM_RD_STRIDE_EN
    logic [AW-1:0] stride = '0;
`endif
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          done;

    logic [DW-1:0] mem [DEPTH];

    // rd_addr is the BRAM's address register, so read data follows it directly
    assign rd_data = mem[rd_addr];

    always #5 clock = ~clock;

    bram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .base_addr(base_addr), .length(length),
`ifdef BRAM_RD_STRIDE_EN
        .stride(stride),
`endif
        .rd_addr(rd_addr), .rd_data(rd_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .busy(busy), .done(done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic mem_ramp();
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 100);
    endtask

    // One range: model the word list, drive start, watch every cycle until done
    task automatic run_xfer(input string nm, input int base, input int len, input int inc,
                            input int mode, input bit poke, output int beats,
                            output logic [DW-1:0] first_d, output logic [DW-1:0] last_d);
        logic [DW:0]   exp_q [$];
        logic [DW:0]   e;
        int            eff_inc, c, budget, done_c, first_v, first_x, last_x, busy_n;
        bit            hold_pend, prev_last;
        logic [DW-1:0] prev_data;
`ifdef BRAM_RD_STRIDE_EN
        eff_inc = inc;
`else
        eff_inc = 1;
`endif
        for (int k = 0; k < len; k++)
            exp_q.push_back({k == len - 1, mem[(base + k * eff_inc) % DEPTH]});
        beats = 0; first_d = '0; last_d = '0;
        done_c = -1; first_v = -1; first_x = -1; last_x = -1; busy_n = 0;
        hold_pend = 1'b0; prev_last = 1'b0; prev_data = '0;
        budget = 8 * len + 40;
        @(negedge clock);
        base_addr = AW'(base);
        length    = (AW+1)'(len);
`ifdef BRAM_RD_STRIDE_EN
        stride    = AW'(inc);
`endif
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        c = 1;
        while (c <= budget) begin
            if (c > 1) @(negedge clock);
            case (mode)
                0:       m_ready = 1'b1;
                1:       m_ready = ((c - 1) % 4 == 0) || ((c - 1) % 4 == 3);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            if (poke && c == 3) begin
                start = 1'b1; base_addr = AW'(base + 7); length = 5'd5;
            end
            if (poke && c == 4) start = 1'b0;
            if (busy) busy_n++;
            if (hold_pend)
                chk({nm, " hold"}, {m_valid, m_last, m_data}, {1'b1, prev_last, prev_data});
            hold_pend = m_valid && !m_ready;
            prev_last = m_last;
            prev_data = m_data;
            if (m_valid && first_v < 0) first_v = c;
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) chk({nm, " extra beat"}, 1, 0);
                else begin
                    e = exp_q.pop_front();
                    chk({nm, " beat"}, {m_last, m_data}, e);
                end
                if (beats == 0) begin first_d = m_data; first_x = c; end
                last_d = m_data; last_x = c; beats++;
            end
            if (done) begin done_c = c; break; end
            c++;
        end
        start = 1'b0;
        if (done_c < 0) chk({nm, " done timeout"}, 0, 1);
        chk({nm, " leftover"}, exp_q.size(), 0);
        chk({nm, " busy span"}, busy_n, (done_c < 0) ? budget : done_c);
        if (len > 0) begin
            chk({nm, " done lat"}, done_c, last_x + 1);
            chk({nm, " first lat"}, first_v, 3);
            if (mode == 0) chk({nm, " rate"}, last_x - first_x, len - 1);
        end else begin
            chk({nm, " zero valid"}, first_v, -1);
        end
        @(negedge clock);
        chk({nm, " idle"}, {busy, done, m_valid}, 3'b000);
        m_ready = 1'b0;
    endtask

    typedef struct {
        int base; int len; int mode; bit poke;
        int exp_beats; int exp_first; int exp_last;
    } vec_t;

    vec_t vecs [7];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int            beats, nx;
        logic [DW-1:0] fd, ld;
        bit            quiet;

        vecs[0] = '{2,  4,  0, 1'b0, 4,  102, 105};
        vecs[1] = '{14, 4,  0, 1'b0, 4,  114, 101};
        vecs[2] = '{0,  6,  1, 1'b0, 6,  100, 105};
        vecs[3] = '{3,  0,  0, 1'b0, 0,  0,   0};
        vecs[4] = '{0,  16, 0, 1'b0, 16, 100, 115};
        vecs[5] = '{5,  18, 1, 1'b0, 18, 105, 106};
        vecs[6] = '{9,  3,  0, 1'b1, 3,  109, 111};

        mem_ramp();
        repeat (2) @(negedge clock);
        chk("reset rd_addr", rd_addr, 0);
        chk("reset m_valid", m_valid, 0);
        chk("reset m_data",  m_data,  0);
        chk("reset m_last",  m_last,  0);
        chk("reset busy",    busy,    0);
        chk("reset done",    done,    0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        for (int i = 0; i < 7; i++) begin
            run_xfer($sformatf("vec%0d", i), vecs[i].base, vecs[i].len, 1,
                     vecs[i].mode, vecs[i].poke, beats, fd, ld);
            chk($sformatf("vec%0d beats", i), beats, vecs[i].exp_beats);
            if (vecs[i].exp_beats > 0) begin
                chk($sformatf("vec%0d first", i), fd, vecs[i].exp_first);
                chk($sformatf("vec%0d last", i),  ld, vecs[i].exp_last);
            end
        end

        // Reset after 2 of 8 beats, then replay from base
        @(negedge clock);
        base_addr = 4'd5; length = 5'd8; start = 1'b1;
        @(negedge clock);
        start = 1'b0; m_ready = 1'b1; nx = 0;
        for (int c = 0; c < 20 && nx < 2; c++) begin
            if (c > 0) @(negedge clock);
            if (m_valid && m_ready) begin
                chk("rst beat", m_data, DW'(105 + nx));
                nx++;
            end
        end
        chk("rst beats seen", nx, 2);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("rst outs", {rd_addr, m_valid, m_data, m_last, busy, done}, 0);
        @(negedge clock);
        reset_n = 1'b1; m_ready = 1'b0; quiet = 1'b1;
        repeat (3) begin
            @(negedge clock);
            if (done || busy || m_valid) quiet = 1'b0;
        end
        chk("rst quiet", quiet, 1);
        run_xfer("replay", 5, 8, 1, 0, 1'b0, beats, fd, ld);
        chk("replay beats", beats, 8);
        chk("replay first", fd, 105);
        chk("replay last",  ld, 112);

`ifdef BRAM_RD_STRIDE_EN
        run_xfer("stride3", 0, 5, 3, 0, 1'b0, beats, fd, ld);
        chk("stride3 beats", beats, 5);
        chk("stride3 first", fd, 100);
        chk("stride3 last",  ld, 112);
        run_xfer("stride0", 7, 3, 0, 1, 1'b0, beats, fd, ld);
        chk("stride0 beats", beats, 3);
        chk("stride0 last",  ld, 107);
`endif

        for (int r = 0; r < 25; r++) begin
            int b, l, s;
            for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
            b = $urandom_range(0, DEPTH - 1);
            l = $urandom_range(0, 20);
            s = $urandom_range(0, DEPTH - 1);
            run_xfer($sformatf("rnd%0d", r), b, l, s, 2, (l >= 3) && ($urandom_range(0, 1) == 1),
                     beats, fd, ld);
            chk($sformatf("rnd%0d beats", r), beats, l);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
